// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes eight BCD/hex nibbles onto a common 8-bit segment bus with
// one select line per digit. The inputs are captured into shadow registers at
// the start of every frame, so a mid-frame change never tears the display.
// Each digit slot starts with a short dark gap to suppress ghosting.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   en_in          1 = scanning, 0 = display dark
//   bcd_in         digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   dp_in          decimal point per digit, 1 = lit
//   blank_mask_in  1 = digit i is never selected
//   seg_out        {dp,g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW
//   sel_out        sel_out[i] drives digit i, inverted when SEL_ACTIVE_LOW
//   frame_done_out one-cycle pulse on the edge that completes a frame
module seg7_scan_driver #(
   parameter int unsigned FREQUENCY_IN   = 50_000_000,
   parameter int unsigned SCAN_FREQ      = 1000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned SEL_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_in,
   input  logic [31:0] bcd_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blank_mask_in,
   output logic [7:0]  seg_out,
   output logic [7:0]  sel_out,
   output logic        frame_done_out
);

   localparam int unsigned DIV   = FREQUENCY_IN / SCAN_FREQ;
   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

   localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [7:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StShow
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      bcd_sh_q;
   logic [7:0]       dp_sh_q;
   logic [7:0]       mask_sh_q;
   logic             load_shadow;
   logic             frame_done_d;
   logic [7:0]       seg_d, sel_d;
   logic [7:0]       seg_raw, sel_raw;
   logic [3:0]       nibble;

   // Active-high segment pattern {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] val);
      logic [6:0] pat;
      unique case (val)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         default: pat = 7'h71;
      endcase
      return pat;
   endfunction

   // Next-state: slot counter, digit index, shadow load and frame pulse.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      load_shadow  = 1'b0;
      frame_done_d = 1'b0;

      if (!en_in) begin
         // Disable wins over a coincident wrap: no load, no frame pulse.
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (state_q == StIdle) begin
         cnt_d       = '0;
         idx_d       = '0;
         load_shadow = 1'b1;
         state_d     = (BLANK_LIM != '0) ? StBlank : StShow;
      end else begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               load_shadow  = 1'b1;
               frame_done_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         state_d = (cnt_d < BLANK_LIM) ? StBlank : StShow;
      end
   end

   // Output pattern for the current slot; registered below, so the pins lag
   // the state/counter/index by one cycle.
   always_comb begin
      nibble  = bcd_sh_q[{idx_q, 2'b00} +: 4];
      seg_raw = 8'h00;
      sel_raw = 8'h00;
      if (en_in && (state_q == StShow) && !mask_sh_q[idx_q]) begin
         seg_raw = {dp_sh_q[idx_q], decode(nibble)};
         sel_raw = 8'h01 << idx_q;
      end
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      sel_d = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         idx_q          <= '0;
         bcd_sh_q       <= '0;
         dp_sh_q        <= '0;
         mask_sh_q      <= '0;
         seg_out        <= SEG_OFF;
         sel_out        <= SEL_OFF;
         frame_done_out <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         seg_out        <= seg_d;
         sel_out        <= sel_d;
         frame_done_out <= frame_done_d;
         if (load_shadow) begin
            bcd_sh_q  <= bcd_in;
            dp_sh_q   <= dp_in;
            mask_sh_q <= blank_mask_in;
         end
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 8-digit BCD moving-ID bus.
- Time-multiplexes 8 BCD/hex nibbles onto one common 8-bit segment bus with per-digit select lines.
- Snapshots the input once per frame so a digit shift never tears mid-frame.
- Adds a ghost-blanking gap at the start of every digit slot.

Parameters:
- FREQUENCY_IN, 50_000_000: input clock frequency, Hz.
- SCAN_FREQ, 1000: digit slot rate, Hz. DIV = FREQUENCY_IN/SCAN_FREQ cycles per slot; DIV >= 2 required.
- BLANK_CYCLES, 16: cycles at the start of each slot with all selects inactive. Must satisfy BLANK_CYCLES < DIV; 0 means no blanking.
- SEG_ACTIVE_LOW, 1: 1 means seg_out is inverted (common anode).
- SEL_ACTIVE_LOW, 1: 1 means sel_out is inverted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- en_in, input, 1: 1 = scanning, 0 = display dark.
- bcd_in, input, 32: digit i = bcd_in[4i+3:4i]; digit 0 is rightmost.
- dp_in, input, 8: decimal point per digit, 1 = lit.
- blank_mask_in, input, 8: 1 = digit i never selected.
- seg_out, output, 8: {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- sel_out, output, 8: sel_out[i] drives digit i, polarity per SEL_ACTIVE_LOW.
- frame_done_out, output, 1: one-cycle pulse when a frame completes.

Behaviour:
- "Inactive" means all segments off / no digit selected. In active-low mode both buses are 8'hFF; in active-high mode both are 8'h00.
- Reset (async, immediate):
  - seg_out and sel_out inactive; frame_done_out = 0.
  - slot counter = 0, digit index = 0, state = IDLE, shadow registers = 0.
- Slot counter: counts 0..DIV-1 while scanning. At DIV-1 it wraps to 0 and the digit index advances, wrapping 7 to 0.
- States:
  - IDLE: entered when en_in = 0; counter and index held at 0, outputs inactive.
  - IDLE to BLANK: on en_in = 1. In that same edge, shadow registers load bcd_in, dp_in and blank_mask_in, and slot 0 starts.
  - BLANK: while counter < BLANK_CYCLES; sel_out inactive, seg_out inactive.
  - SHOW: while counter >= BLANK_CYCLES.
    - sel_out asserts only bit[index], and only if shadow mask[index] = 0.
    - seg_out = decode(shadow nibble[index]) with dp = shadow dp[index].
    - If the digit is masked, seg_out is inactive too.
  - Any state to IDLE: en_in = 0 sampled. Outputs go inactive on the next edge.
- Frame snapshot:
  - Shadow registers reload when the counter wraps while index = 7, i.e. at the 7-to-0 transition.
  - frame_done_out pulses on that same edge.
  - Input changes mid-frame take effect only in the next frame.
- Decode (active-high pattern; invert when SEG_ACTIVE_LOW):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp is bit 7.
- Latency: seg_out and sel_out are registered; each reflects the state/counter/index of the previous cycle (1 cycle).
- Timing: slot = DIV cycles, of which BLANK_CYCLES are dark. Frame = 8*DIV cycles.
- Simultaneous events:
  - rst dominates everything.
  - en_in falling on a wrap edge: IDLE wins, no shadow load, no frame_done.

Test Plan:
Bench parameters: FREQUENCY_IN=1000, SCAN_FREQ=100 (DIV=10), BLANK_CYCLES=2, both polarities active-low.
1. Basic decode: en_in=1, bcd_in=32'h76543210, dp=0, mask=0 -> per slot, 2 cycles sel=FF/seg=FF, then 8 cycles with the following values:
   - sel=FE/seg=C0, FD/F9, FB/A4, F7/B0
   - EF/99, DF/92, BF/82, 7F/F8
2. Frame timing: run 3 frames -> frame_done_out high exactly 1 cycle every 80 cycles, coincident with the index 7-to-0 wrap.
3. Snapshot: bcd_in=32'h11111111, then change to 32'h22222222 during slot 3 -> slots 3..7 still show seg=F9; the next frame shows seg=A4 on all digits.
4. Mask and dp: bcd_in=0, dp_in=8'h01, blank_mask_in=8'h80 -> digit 0 seg=8'h40; during slot 7, sel=FF and seg=FF for all 10 cycles.
5. Enable toggle: drop en_in in slot 4 SHOW -> next edge sel=FF/seg=FF and frame_done stays 0. Re-raise en_in -> slot 0 gives 2 blank cycles, then sel=FE.
6. Async reset: assert rst mid-SHOW between clock edges -> sel_out=FF, seg_out=FF, frame_done_out=0 immediately without a clock edge. After release with en_in=1, scanning restarts at slot 0 BLANK.
